init_sequencer: RTL and testbench
=================================

Name: init_sequencer

Overview:
- Parametrised memory-initialisation sequencer. On a start request it sweeps addresses 0..DEPTH-1 and writes a constant fill value into one, all, or each in turn of NUM_BANKS memory banks.
- Adds four things beyond a fixed 8-entry counter: a start/busy/done handshake, a downstream ready stall, abort, and bank-selection modes.
- Sits between the top-level control FSM and the clause/variable RAM banks. It runs at power-up and whenever a new problem is loaded.

Parameters:
- DEPTH, 8, number of entries per bank (>=2).
- ADDR_W, $clog2(DEPTH), address width.
- DATA_W, 8, fill data width.
- NUM_BANKS, 4, number of memory banks (>=1).
- BANK_W, max(1,$clog2(NUM_BANKS)), bank index width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request sweep; sampled only in IDLE.
- mode  input  2  0=single bank, 1=all banks in parallel, 2=banks sequentially 0..NUM_BANKS-1, 3=reserved (treated as 0).
- bank_sel  input  BANK_W  target bank for mode 0/3.
- fill_value  input  DATA_W  data written to every entry.
- abort  input  1  terminate a sweep in progress.
- ready  input  1  memory accepts a write this cycle.
- address  output  ADDR_W  current write address.
- wr_data  output  DATA_W  latched fill value.
- wr_en  output  NUM_BANKS  per-bank write strobe.
- bank_cur  output  BANK_W  bank being written (mode 2), else latched bank_sel (0 in mode 1).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.
- err  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (async): state=IDLE; address, wr_data, bank_cur, busy, done, err and all wr_en = 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 with bank_sel<NUM_BANKS (or mode 1/2): latch mode, bank_sel and fill_value; set address=0; set bank_cur=0 for modes 1/2, else bank_sel; go to RUN.
  - start=1 in mode 0/3 with bank_sel>=NUM_BANKS: stay in IDLE and pulse err for one cycle the next cycle.
  - Inputs are sampled at the clock edge, so the first write is presented the cycle after start.
- RUN:
  - busy=1.
  - wr_en is combinational: (state==RUN) & ready & ~abort, applied through a bank mask.
  - Bank mask: mode 0/3 selects bit bank_cur; mode 1 selects all bits; mode 2 selects bit bank_cur.
  - A write is accepted on each edge where wr_en is non-zero.
  - ready=0 holds address and bank_cur unchanged (stall); there is no limit on stall length.
  - Accepted write with address<DEPTH-1: address+1.
  - Accepted write with address==DEPTH-1: in mode 2 with bank_cur<NUM_BANKS-1, set address=0, bank_cur+1 and stay in RUN; otherwise set address=0 and go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start during DONE is ignored.
- abort=1 in RUN:
  - wr_en is forced to 0 in that same cycle.
  - Next state is IDLE with address=0; done is not pulsed.
  - abort has priority over ready and over the last-address transition.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored: latched values and progress are unchanged, no err.
- Changing fill_value, mode or bank_sel mid-sweep has no effect (latched values are used).
- Write counts:
  - Modes 0/1: exactly DEPTH accepted write cycles.
  - Mode 2: exactly DEPTH*NUM_BANKS cycles, each bank written in address order 0..DEPTH-1.
- Minimum latency, start to done pulse, with ready tied high:
  - Modes 0/1: DEPTH+1 cycles.
  - Mode 2: DEPTH*NUM_BANKS+1 cycles.
- Address arithmetic is within ADDR_W. A non-power-of-2 DEPTH wraps at DEPTH-1, never at 2^ADDR_W-1.
- rst asserted mid-sweep returns to IDLE immediately and asynchronously; all outputs become 0.

Test Plan (DEPTH=8, NUM_BANKS=4, DATA_W=8):
1. Mode 0, bank_sel=2, fill=0xA5, ready=1 -> wr_en=4'b0100 for 8 cycles; address 0..7; wr_data=0xA5; done pulses on cycle 9 after start; busy high for cycles 1-8.
2. Mode 2, fill=0x00, ready=1 -> 32 writes; bank_cur 0,1,2,3 each with addresses 0..7; wr_en one-hot tracks bank_cur; single done pulse at cycle 33.
3. Mode 1 with ready low on cycles 3-5 -> wr_en=4'b1111 except 4'b0000 during the stall; address holds at 2 during the stall; total of 8 accepted writes; done at cycle 12.
4. Mode 0 sweep, abort at address=5 -> wr_en=0 that cycle; IDLE next cycle with address=0; no done pulse; a fresh start afterwards completes normally.
5. Second start at address=3 of a mode 0 sweep, with a different fill_value and bank_sel -> ignored; the sweep finishes unchanged with the original bank and data.
6. Non-power-of-2 build (DEPTH=5, NUM_BANKS=3) with mode 0, bank_sel=3 -> err pulse, stays IDLE, no wr_en. Then mode 0, bank_sel=1 -> addresses 0..4, done at cycle 6. Async rst mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/init_sequencer.sv
// rtl/init_sequencer.sv - memory-initialisation sequencer: sweeps 0..DEPTH-1 writing a fill value
// into one bank, all banks in parallel, or each bank in turn.
module init_sequencer #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 4,
  parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [BANK_W-1:0]    bank_sel,
  input  logic [DATA_W-1:0]    fill_value,
  input  logic                 abort,
  input  logic                 ready,
  output logic [ADDR_W-1:0]    address,
  output logic [DATA_W-1:0]    wr_data,
  output logic [NUM_BANKS-1:0] wr_en,
  output logic [BANK_W-1:0]    bank_cur,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK  = BANK_W'(NUM_BANKS - 1);
  localparam logic [BANK_W:0]   BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

  logic [1:0]           state;
  logic [1:0]           mode_q;
  logic                 sel_ok;
  logic                 multi_bank;
  logic [NUM_BANKS-1:0] bank_mask;

  // Modes 1 and 2 ignore bank_sel, so only single-bank requests can be out of range.
  assign multi_bank = (mode == 2'd1) || (mode == 2'd2);
  assign sel_ok     = multi_bank || ({1'b0, bank_sel} < BANK_LIMIT);

  always_comb begin
    bank_mask = NUM_BANKS'(1) << bank_cur;
    if (mode_q == 2'd1) begin
      bank_mask = '1;
    end
  end

  assign wr_en = (state == S_RUN && ready && !abort) ? bank_mask : '0;
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_q   <= 2'd0;
      address  <= '0;
      wr_data  <= '0;
      bank_cur <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (sel_ok) begin
              state    <= S_RUN;
              mode_q   <= mode;
              wr_data  <= fill_value;
              address  <= '0;
              bank_cur <= multi_bank ? '0 : bank_sel;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // abort outranks both the stall and the end-of-bank transition.
          if (abort) begin
            state   <= S_IDLE;
            address <= '0;
          end else if (ready) begin
            if (address == LAST_ADDR) begin
              address <= '0;
              if (mode_q == 2'd2 && bank_cur != LAST_BANK) begin
                bank_cur <= bank_cur + BANK_W'(1);
              end else begin
                state <= S_DONE;
              end
            end else begin
              address <= address + ADDR_W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// tb/tb_init_sequencer.sv - directed scoreboard bench for init_sequencer (8x4 and 5x3 builds).
module tb_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Build A: DEPTH=8, NUM_BANKS=4
  logic       rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b1;
  logic [1:0] mode_a = 2'd0, bank_sel_a = 2'd0, bank_cur_a;
  logic [7:0] fill_a = 8'h00, wr_data_a;
  logic [2:0] address_a;
  logic [3:0] wr_en_a;
  logic       busy_a, done_a, err_a;

  init_sequencer #(.DEPTH(8), .DATA_W(8), .NUM_BANKS(4)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .mode(mode_a), .bank_sel(bank_sel_a),
    .fill_value(fill_a), .abort(abort_a), .ready(ready_a), .address(address_a),
    .wr_data(wr_data_a), .wr_en(wr_en_a), .bank_cur(bank_cur_a), .busy(busy_a),
    .done(done_a), .err(err_a)
  );

  // Build B: DEPTH=5, NUM_BANKS=3
  logic       rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b1;
  logic [1:0] mode_b = 2'd0, bank_sel_b = 2'd0, bank_cur_b;
  logic [7:0] fill_b = 8'h00, wr_data_b;
  logic [2:0] address_b;
  logic [2:0] wr_en_b;
  logic       busy_b, done_b, err_b;

  init_sequencer #(.DEPTH(5), .DATA_W(8), .NUM_BANKS(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .mode(mode_b), .bank_sel(bank_sel_b),
    .fill_value(fill_b), .abort(abort_b), .ready(ready_b), .address(address_b),
    .wr_data(wr_data_b), .wr_en(wr_en_b), .bank_cur(bank_cur_b), .busy(busy_b),
    .done(done_b), .err(err_b)
  );

  // Expected writes: {wr_en, bank_cur, address, wr_data}
  logic [16:0] qa[$];
  logic [15:0] qb[$];
  int done_cnt_a = 0, err_cnt_a = 0;

  always @(negedge clk) begin
    if (!rst_a) begin
      if (done_a) done_cnt_a++;
      if (err_a) err_cnt_a++;
      if (wr_en_a != 4'b0) begin
        if (qa.size() == 0) check("unexpected_write_a", {28'd0, wr_en_a}, 32'd0);
        else check("write_a", {15'd0, wr_en_a, bank_cur_a, address_a, wr_data_a}, {15'd0, qa.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && wr_en_b != 3'b0) begin
      if (qb.size() == 0) check("unexpected_write_b", {29'd0, wr_en_b}, 32'd0);
      else check("write_b", {16'd0, wr_en_b, bank_cur_b, address_b, wr_data_b}, {16'd0, qb.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [3:0] en, input int bank, input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) qa.push_back({en, 2'(bank), 3'(i), d});
  endtask

  // Start is already driven; runs build A until done or abort and reports latency and busy cycles.
  task automatic sweep_a(input int stall_lo, input int stall_hi, input int abort_c,
                         input int restart_c, output int lat, output int busy_n);
    bit hit_abort;
    lat = 0; busy_n = 0;
    cyc(); lat = 1; start_a = 1'b0;
    while (lat < 200) begin
      ready_a = !(lat >= stall_lo && lat <= stall_hi);
      abort_a = (lat == abort_c);
      if (lat == restart_c) begin
        start_a = 1'b1; mode_a = 2'd0; bank_sel_a = 2'd1; fill_a = 8'h3C;
      end else begin
        start_a = 1'b0;
      end
      #1;
      if (busy_a) busy_n++;
      if (lat == abort_c) check("abort_wr_en", {28'd0, wr_en_a}, 32'd0);
      hit_abort = (lat == abort_c);
      cyc(); lat++;
      if (done_a || hit_abort) break;
    end
    if (lat >= 200) check("sweep_timeout", 32'd1, 32'd0);
    ready_a = 1'b1; abort_a = 1'b0; start_a = 1'b0;
  endtask

  initial begin
    int lat, busy_n, d0, e0;

    #12;
    check("rst_addr", {29'd0, address_a}, 32'd0);
    check("rst_outs", {24'd0, wr_en_a, busy_a, done_a, err_a, 1'b0}, 32'd0);
    check("rst_data", {22'd0, wr_data_a, bank_cur_a}, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    cyc();

    // 1: mode 0, bank 2
    d0 = done_cnt_a;
    start_a = 1'b1; mode_a = 2'd0; bank_sel_a = 2'd2; fill_a = 8'hA5;
    push_a(4'b0100, 2, 8, 8'hA5);
    sweep_a(-1, -1, -1, -1, lat, busy_n);
    check("t1_latency", lat, 32'd9);
    check("t1_busy_cycles", busy_n, 32'd8);
    check("t1_busy_in_done", {31'd0, busy_a}, 32'd0);
    cyc();
    check("t1_done_one_cycle", {31'd0, done_a}, 32'd0);
    check("t1_done_count", done_cnt_a - d0, 32'd1);
    check("t1_queue_empty", qa.size(), 32'd0);

    // 2: mode 2, every bank in turn
    d0 = done_cnt_a;
    start_a = 1'b1; mode_a = 2'd2; bank_sel_a = 2'd3; fill_a = 8'h00;
    for (int b = 0; b < 4; b++) push_a(4'(1 << b), b, 8, 8'h00);
    sweep_a(-1, -1, -1, -1, lat, busy_n);
    check("t2_latency", lat, 32'd33);
    cyc();
    check("t2_done_count", done_cnt_a - d0, 32'd1);
    check("t2_queue_empty", qa.size(), 32'd0);

    // 3: mode 1 with a three-cycle stall
    start_a = 1'b1; mode_a = 2'd1; bank_sel_a = 2'd2; fill_a = 8'h77;
    push_a(4'b1111, 0, 8, 8'h77);
    cyc(); start_a = 1'b0;
    cyc(); cyc();
    ready_a = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      #1;
      check("t3_stall_wr_en", {28'd0, wr_en_a}, 32'd0);
      check("t3_stall_addr", {29'd0, address_a}, 32'd2);
      cyc();
    end
    ready_a = 1'b1;
    lat = 6;
    while (!done_a && lat < 200) begin cyc(); lat++; end
    check("t3_latency", lat, 32'd12);
    check("t3_queue_empty", qa.size(), 32'd0);
    cyc();

    // 4: abort at address 5, then a fresh start
    d0 = done_cnt_a;
    start_a = 1'b1; mode_a = 2'd0; bank_sel_a = 2'd1; fill_a = 8'h11;
    push_a(4'b0010, 1, 5, 8'h11);
    sweep_a(-1, -1, 6, -1, lat, busy_n);
    check("t4_abort_idle", {31'd0, busy_a}, 32'd0);
    check("t4_abort_addr", {29'd0, address_a}, 32'd0);
    cyc();
    check("t4_no_done", done_cnt_a - d0, 32'd0);
    check("t4_queue_empty", qa.size(), 32'd0);
    start_a = 1'b1; mode_a = 2'd0; bank_sel_a = 2'd0; fill_a = 8'h5A;
    push_a(4'b0001, 0, 8, 8'h5A);
    sweep_a(-1, -1, -1, -1, lat, busy_n);
    check("t4_restart_latency", lat, 32'd9);
    cyc();
    check("t4_restart_queue", qa.size(), 32'd0);

    // 5: second start mid-sweep is ignored
    e0 = err_cnt_a;
    start_a = 1'b1; mode_a = 2'd0; bank_sel_a = 2'd3; fill_a = 8'hC3;
    push_a(4'b1000, 3, 8, 8'hC3);
    sweep_a(-1, -1, -1, 4, lat, busy_n);
    check("t5_latency", lat, 32'd9);
    check("t5_wr_data", {24'd0, wr_data_a}, 32'h0000_00C3);
    cyc();
    check("t5_queue_empty", qa.size(), 32'd0);
    check("t5_no_err", err_cnt_a - e0, 32'd0);

    // 6: DEPTH=5, NUM_BANKS=3 build
    start_b = 1'b1; mode_b = 2'd0; bank_sel_b = 2'd3; fill_b = 8'h99;
    cyc(); start_b = 1'b0;
    check("t6_err_pulse", {31'd0, err_b}, 32'd1);
    check("t6_stay_idle", {31'd0, busy_b}, 32'd0);
    cyc();
    check("t6_err_clear", {31'd0, err_b}, 32'd0);
    start_b = 1'b1; bank_sel_b = 2'd1; fill_b = 8'h42;
    for (int i = 0; i < 5; i++) qb.push_back({3'b010, 2'd1, 3'(i), 8'h42});
    cyc(); start_b = 1'b0; lat = 1;
    while (!done_b && lat < 200) begin cyc(); lat++; end
    check("t6_latency", lat, 32'd6);
    check("t6_queue_empty", qb.size(), 32'd0);
    cyc();
    start_b = 1'b1; bank_sel_b = 2'd2; fill_b = 8'hE7;
    for (int i = 0; i < 5; i++) qb.push_back({3'b100, 2'd2, 3'(i), 8'hE7});
    cyc(); start_b = 1'b0;
    cyc(); cyc();
    #2;
    rst_b = 1'b1;
    #1;
    qb.delete();
    check("t6_async_rst_wr_en", {29'd0, wr_en_b}, 32'd0);
    check("t6_async_rst_flags", {29'd0, busy_b, done_b, err_b}, 32'd0);
    check("t6_async_rst_regs", {19'd0, address_b, bank_cur_b, wr_data_b}, 32'd0);
    cyc();
    rst_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
